// File: rtl/matmul_tile_sequencer_pkg.sv
// rtl/matmul_tile_sequencer_pkg.sv - shared types and helpers for the matmul tile sequencer
// Contents: tile_seq_state_t (sequencer FSM states), ceil_div (weight tile count).
package acc_types;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } tile_seq_state_t;

    // Number of den-wide tiles needed to cover num columns.
    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 32'd1) / den;
    endfunction

endpackage

// File: rtl/tile_seq_delay_line.sv
// rtl/tile_seq_delay_line.sv - DEPTH-deep valid+address shift register with async active-low clear
// Ports: clk_i, rst_i (async, active low), in_valid_i/in_addr_i (stage input),
//        out_valid_o/out_addr_o (input delayed by exactly DEPTH cycles).
module tile_seq_delay_line #(
    parameter int unsigned DEPTH  = 9,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    output logic              out_valid_o,
    output logic [ADDR_W-1:0] out_addr_o
);

    logic [DEPTH-1:0]  vld_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= in_valid_i;
            addr_q[0] <= in_addr_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign out_valid_o = vld_q[DEPTH-1];
    assign out_addr_o  = addr_q[DEPTH-1];

endmodule

// File: rtl/matmul_tile_sequencer.sv
// rtl/matmul_tile_sequencer.sv - multi-tile weight-load / stream / drain sequencer for the MAC array
// Ports: clk_i, rst_i (async, active low); start_i, H_DIM_i, W_DIM_i, ub_base_i (run request);
//        weight_valid_i / load_weights_o (weight FIFO); ub_rd_o, ub_rd_addr_o (activation reads);
//        mac_compute_o; acc_wr_o, acc_addr_wr_o, acc_col_mask_o (accumulator); tile_idx_o;
//        busy_o, done_o (handshake).
// Optional: TILE_SEQ_PERF_EN adds perf_cycles_o / perf_wstall_o saturating counters.
module matmul_tile_sequencer
    import acc_types::*;
#(
    parameter int unsigned ARRAY_DIM  = 32,
    parameter int unsigned DIM_W      = 9,
    parameter int unsigned UB_ADDR_W  = 12,
    parameter int unsigned ACC_ADDR_W = 7,
    parameter int unsigned PIPE_LAT   = 2*ARRAY_DIM+1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DIM_W-1:0]      H_DIM_i,
    input  logic [DIM_W-1:0]      W_DIM_i,
    input  logic [UB_ADDR_W-1:0]  ub_base_i,
    input  logic                  weight_valid_i,
    output logic                  load_weights_o,
    output logic                  ub_rd_o,
    output logic [UB_ADDR_W-1:0]  ub_rd_addr_o,
    output logic                  mac_compute_o,
    output logic                  acc_wr_o,
    output logic [ACC_ADDR_W-1:0] acc_addr_wr_o,
    output logic [ARRAY_DIM-1:0]  acc_col_mask_o,
    output logic [DIM_W-1:0]      tile_idx_o,
`ifdef TILE_SEQ_PERF_EN
    output logic [31:0]           perf_cycles_o,
    output logic [31:0]           perf_wstall_o,
`endif
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned BEAT_W  = $clog2(ARRAY_DIM + 1);
    localparam int unsigned DRAIN_W = $clog2(PIPE_LAT + 1);

    tile_seq_state_t state_q, state_d;

    logic [DIM_W-1:0]     h_q, w_q, tiles_q, tile_q, row_q;
    logic [UB_ADDR_W-1:0] base_q;
    logic [BEAT_W-1:0]    beat_q;
    logic [DRAIN_W-1:0]   drain_q;

    logic beat_last, row_last, drain_last, tile_last, in_tile;

    assign beat_last  = (beat_q == BEAT_W'(ARRAY_DIM - 1));
    assign row_last   = (row_q == h_q - DIM_W'(1));
    assign drain_last = (drain_q == DRAIN_W'(PIPE_LAT - 1));
    assign tile_last  = (tile_q == tiles_q - DIM_W'(1));
    assign in_tile    = (state_q == ST_LOAD_W) || (state_q == ST_STREAM) || (state_q == ST_DRAIN);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_weights_o = 1'b0;
        ub_rd_o        = 1'b0;
        mac_compute_o  = 1'b0;
        done_o         = 1'b0;
        busy_o         = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = (H_DIM_i == '0 || W_DIM_i == '0) ? ST_DONE : ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                load_weights_o = weight_valid_i;
                if (weight_valid_i && beat_last) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                ub_rd_o       = 1'b1;
                mac_compute_o = 1'b1;
                if (row_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                mac_compute_o = 1'b1;
                if (drain_last) begin
                    state_d = tile_last ? ST_DONE : ST_LOAD_W;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            h_q     <= '0;
            w_q     <= '0;
            tiles_q <= '0;
            tile_q  <= '0;
            row_q   <= '0;
            base_q  <= '0;
            beat_q  <= '0;
            drain_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        h_q     <= H_DIM_i;
                        w_q     <= W_DIM_i;
                        base_q  <= ub_base_i;
                        tiles_q <= DIM_W'(ceil_div(32'(W_DIM_i), ARRAY_DIM));
                        tile_q  <= '0;
                        row_q   <= '0;
                        beat_q  <= '0;
                        drain_q <= '0;
                    end
                end
                ST_LOAD_W: begin
                    if (weight_valid_i) begin
                        beat_q <= beat_last ? '0 : beat_q + BEAT_W'(1);
                    end
                end
                ST_STREAM: begin
                    row_q <= row_last ? '0 : row_q + DIM_W'(1);
                end
                ST_DRAIN: begin
                    if (drain_last) begin
                        drain_q <= '0;
                        if (!tile_last) begin
                            tile_q <= tile_q + DIM_W'(1);
                        end
                    end else begin
                        drain_q <= drain_q + DRAIN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Address is forced to zero outside STREAM so the bus stays quiet between reads.
    assign ub_rd_addr_o = ub_rd_o ? base_q + UB_ADDR_W'(row_q) : '0;
    assign tile_idx_o   = in_tile ? tile_q : '0;

    // Only the last tile of a width that is not a multiple of ARRAY_DIM is partial.
    always_comb begin
        int unsigned rem;
        logic        partial;
        rem            = 32'(w_q) % ARRAY_DIM;
        partial        = tile_last && (rem != 0);
        acc_col_mask_o = '0;
        if (in_tile) begin
            for (int unsigned i = 0; i < ARRAY_DIM; i++) begin
                acc_col_mask_o[i] = !partial || (i < rem);
            end
        end
    end

    tile_seq_delay_line #(
        .DEPTH  (PIPE_LAT),
        .ADDR_W (ACC_ADDR_W)
    ) u_delay (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (ub_rd_o),
        .in_addr_i   (ub_rd_o ? ACC_ADDR_W'(row_q) : '0),
        .out_valid_o (acc_wr_o),
        .out_addr_o  (acc_addr_wr_o)
    );

`ifdef TILE_SEQ_PERF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_cycles_o <= '0;
            perf_wstall_o <= '0;
        end else if (state_q == ST_IDLE) begin
            if (start_i) begin
                perf_cycles_o <= '0;
                perf_wstall_o <= '0;
            end
        end else begin
            if (perf_cycles_o != '1) begin
                perf_cycles_o <= perf_cycles_o + 32'd1;
            end
            if (state_q == ST_LOAD_W && !weight_valid_i && perf_wstall_o != '1) begin
                perf_wstall_o <= perf_wstall_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// tb/tb_matmul_tile_sequencer.sv - self-checking bench for matmul_tile_sequencer (ARRAY_DIM=4, PIPE_LAT=9)
module tb_matmul_tile_sequencer;

    localparam int AD = 4;
    localparam int PL = 9;
    localparam int DW = 9;
    localparam int UW = 12;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          start_i = 1'b0;
    logic [DW-1:0] H_DIM_i = '0;
    logic [DW-1:0] W_DIM_i = '0;
    logic [UW-1:0] ub_base_i = '0;
    logic          weight_valid_i = 1'b0;
    logic          load_weights_o, ub_rd_o, mac_compute_o, acc_wr_o, busy_o, done_o;
    logic [UW-1:0] ub_rd_addr_o;
    logic [AW-1:0] acc_addr_wr_o;
    logic [AD-1:0] acc_col_mask_o;
    logic [DW-1:0] tile_idx_o;
`ifdef TILE_SEQ_PERF_EN
    logic [31:0]   perf_cycles_o, perf_wstall_o;
`endif

    matmul_tile_sequencer #(
        .ARRAY_DIM(AD), .DIM_W(DW), .UB_ADDR_W(UW), .ACC_ADDR_W(AW), .PIPE_LAT(PL)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .H_DIM_i(H_DIM_i), .W_DIM_i(W_DIM_i),
        .ub_base_i(ub_base_i), .weight_valid_i(weight_valid_i), .load_weights_o(load_weights_o),
        .ub_rd_o(ub_rd_o), .ub_rd_addr_o(ub_rd_addr_o), .mac_compute_o(mac_compute_o),
        .acc_wr_o(acc_wr_o), .acc_addr_wr_o(acc_addr_wr_o), .acc_col_mask_o(acc_col_mask_o),
        .tile_idx_o(tile_idx_o),
`ifdef TILE_SEQ_PERF_EN
        .perf_cycles_o(perf_cycles_o), .perf_wstall_o(perf_wstall_o),
`endif
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic bit outs_nonzero();
        bit nz;
        nz = load_weights_o | ub_rd_o | (|ub_rd_addr_o) | mac_compute_o | acc_wr_o |
             (|acc_addr_wr_o) | (|acc_col_mask_o) | (|tile_idx_o) | busy_o | done_o;
`ifdef TILE_SEQ_PERF_EN
        nz = nz | (|perf_cycles_o) | (|perf_wstall_o);
`endif
        return nz;
    endfunction

    typedef struct {
        int rel;
        int addr;
        int mask;
        int tile;
    } ev_t;

    typedef struct {
        int h;
        int w;
        int base;
        int st_start;
        int st_len;
        int exp_done;
        int exp_loads;
    } vec_t;

    ev_t rd_q[$];
    ev_t wr_q[$];

    int e0 = 0;
    bit mon_en = 0;
    bit zero_run = 0;
    bit drive_wv = 0;
    int st_start = 0;
    int st_len = 0;
    int exp_done_c = 0;
    int done_seen, done_rel, load_cnt, busy_err, zero_err;

    function automatic int exp_mask(input int w, input int t);
        int tiles;
        int r;
        tiles = (w + AD - 1) / AD;
        r = w % AD;
        if (t == tiles - 1 && r != 0) return (1 << r) - 1;
        return (1 << AD) - 1;
    endfunction

    always @(posedge clk) begin
        #2;
        if (drive_wv) begin
            weight_valid_i = !((cyc - e0) >= st_start && (cyc - e0) < st_start + st_len);
        end
    end

    always @(negedge clk) begin
        int rel;
        ev_t e;
        if (mon_en) begin
            rel = cyc - e0;
            if (busy_o !== (rel >= 1 && rel <= exp_done_c)) busy_err++;
            if (load_weights_o) load_cnt++;
            if (zero_run && (ub_rd_o || acc_wr_o || load_weights_o || mac_compute_o ||
                             acc_col_mask_o != 0 || tile_idx_o != 0 ||
                             ub_rd_addr_o != 0 || acc_addr_wr_o != 0)) zero_err++;
            if (ub_rd_o) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", rel, -1);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_cycle", rel, e.rel);
                    check("rd_addr", ub_rd_addr_o, e.addr);
                    check("rd_mask", acc_col_mask_o, e.mask);
                    check("rd_tile", tile_idx_o, e.tile);
                end
            end
            if (acc_wr_o) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", rel, -1);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_cycle", rel, e.rel);
                    check("wr_addr", acc_addr_wr_o, e.addr);
                    check("wr_mask", acc_col_mask_o, e.mask);
                end
            end
            if (done_o) begin
                done_seen++;
                done_rel = rel;
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int tiles, ls, rd0;
        rd_q.delete();
        wr_q.delete();
        done_seen = 0;
        done_rel  = -1;
        load_cnt  = 0;
        busy_err  = 0;
        zero_err  = 0;
        @(posedge clk);
        #1;
        e0         = cyc;
        exp_done_c = v.exp_done;
        zero_run   = (v.h == 0 || v.w == 0);
        st_start   = v.st_start;
        st_len     = v.st_len;
        tiles      = (v.w + AD - 1) / AD;
        ls         = 1;
        if (!zero_run) begin
            for (int t = 0; t < tiles; t++) begin
                rd0 = ls + AD + ((t == 0) ? v.st_len : 0);
                for (int r = 0; r < v.h; r++) begin
                    rd_q.push_back('{rel: rd0 + r, addr: (v.base + r) % (1 << UW),
                                     mask: exp_mask(v.w, t), tile: t});
                    wr_q.push_back('{rel: rd0 + r + PL, addr: r % (1 << AW),
                                     mask: exp_mask(v.w, t), tile: t});
                end
                ls = rd0 + v.h + PL;
            end
        end
        weight_valid_i = 1'b1;
        drive_wv       = 1'b1;
        H_DIM_i        = DW'(v.h);
        W_DIM_i        = DW'(v.w);
        ub_base_i      = UW'(v.base);
        start_i        = 1'b1;
        mon_en         = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int i = 0; i < 3000 && done_seen == 0; i++) @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        mon_en   = 1'b0;
        drive_wv = 1'b0;
        check("done_count", done_seen, 1);
        check("done_cycle", done_rel, v.exp_done);
        check("load_pulses", load_cnt, v.exp_loads);
        check("busy_profile_errs", busy_err, 0);
        check("rd_left", rd_q.size(), 0);
        check("wr_left", wr_q.size(), 0);
        if (zero_run) check("quiet_outputs_errs", zero_err, 0);
`ifdef TILE_SEQ_PERF_EN
        check("perf_cycles", perf_cycles_o, v.exp_done);
        check("perf_wstall", perf_wstall_o, v.st_len);
`endif
    endtask

    vec_t vecs[8];

    initial begin
        int k, stray, rel, dn, first, second, b16, b17;

        vecs[0] = '{h: 3,   w: 4, base: 'h010, st_start: 0, st_len: 0, exp_done: 17,  exp_loads: 4};
        vecs[1] = '{h: 2,   w: 6, base: 'h100, st_start: 0, st_len: 0, exp_done: 31,  exp_loads: 8};
        vecs[2] = '{h: 3,   w: 4, base: 'h010, st_start: 3, st_len: 5, exp_done: 22,  exp_loads: 4};
        vecs[3] = '{h: 0,   w: 8, base: 'h055, st_start: 0, st_len: 0, exp_done: 1,   exp_loads: 0};
        vecs[4] = '{h: 5,   w: 4, base: 'hFFE, st_start: 0, st_len: 0, exp_done: 19,  exp_loads: 4};
        vecs[5] = '{h: 1,   w: 9, base: 'h020, st_start: 0, st_len: 0, exp_done: 43,  exp_loads: 12};
        vecs[6] = '{h: 130, w: 4, base: 'h000, st_start: 0, st_len: 0, exp_done: 144, exp_loads: 4};
        vecs[7] = '{h: 4,   w: 0, base: 'h033, st_start: 0, st_len: 0, exp_done: 1,   exp_loads: 0};

        repeat (3) @(posedge clk);
        #1 check("reset_outputs_nonzero", outs_nonzero(), 0);
        rst_i = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of STREAM: immediate quiet outputs, no stray writes.
        @(posedge clk);
        #1;
        H_DIM_i = DW'(20);
        W_DIM_i = DW'(4);
        ub_base_i = UW'('h040);
        weight_valid_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (ub_rd_o) break;
        end
        check("stream_reached", ub_rd_o, 1);
        repeat (3) @(posedge clk);
        #3 rst_i = 1'b0;
        #1 check("mid_stream_reset_outputs_nonzero", outs_nonzero(), 0);
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b1;
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (acc_wr_o || ub_rd_o || load_weights_o) stray++;
        end
        check("activity_after_reset", stray, 0);
        run_vec(vecs[0]);

        // start_i held high: one run at a time, re-accepted only from IDLE.
        @(posedge clk);
        #1;
        e0 = cyc;
        H_DIM_i = DW'(1);
        W_DIM_i = DW'(4);
        ub_base_i = '0;
        weight_valid_i = 1'b1;
        start_i = 1'b1;
        dn = 0;
        first = -1;
        second = -1;
        b16 = -1;
        b17 = -1;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            rel = cyc - e0;
            if (done_o) begin
                dn++;
                if (first < 0) first = rel;
                else if (second < 0) second = rel;
            end
            if (rel == 16) b16 = busy_o;
            if (rel == 17) b17 = busy_o;
            if (rel == 20) start_i = 1'b0;
        end
        check("held_first_done", first, 15);
        check("held_busy_low_after_done", b16, 0);
        check("held_busy_restart", b17, 1);
        check("held_second_done", second, 31);
        check("held_done_total", dn, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_tile_sequencer.md
# matmul_tile_sequencer

Parametrised tile sequencer that runs one complete matrix multiply on the MAC systolic array: it latches the H×W problem size, splits W into ceil(W/ARRAY_DIM) weight tiles and, for each tile, loads weights from the weight FIFO, streams H activation rows from the unified buffer and drains the array into the accumulator. It is the next generation of the single-tile control path in the top-level integration. It adds arbitrary array size, multi-tile sequencing, partial-tile column masking, weight-FIFO backpressure and a start/busy/done handshake.

## Interface
- ARRAY_DIM, 32, systolic array rows/columns and weight-load beats per tile
- DIM_W, 9, width of H_DIM_i / W_DIM_i
- UB_ADDR_W, 12, unified buffer address width
- ACC_ADDR_W, 7, accumulator address width
- PIPE_LAT, 2*ARRAY_DIM+1, cycles from ub_rd_o of a row to that row's MAC output being valid
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  start request, sampled only in IDLE
- H_DIM_i  in  DIM_W  activation rows, latched at start
- W_DIM_i  in  DIM_W  output columns, latched at start
- ub_base_i  in  UB_ADDR_W  first activation row address, latched at start
- weight_valid_i  in  1  weight FIFO has a beat available
- load_weights_o  out  1  pop the weight FIFO and shift the beat into the array
- ub_rd_o  out  1  unified buffer read / activation stage enable
- ub_rd_addr_o  out  UB_ADDR_W  activation row address
- mac_compute_o  out  1  array compute enable (STREAM and DRAIN)
- acc_wr_o  out  1  accumulator write enable
- acc_addr_wr_o  out  ACC_ADDR_W  accumulator row address
- acc_col_mask_o  out  ARRAY_DIM  valid output columns of the current tile
- tile_idx_o  out  DIM_W  current weight tile index
- busy_o  out  1  high from start acceptance until done
- done_o  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE, start_i=1:
  - latch the dims and base address; set tiles = ceil(W/ARRAY_DIM).
  - If H=0 or W=0, go to DONE. Otherwise go to LOAD_W with tile=0.
- start_i is ignored outside IDLE.
- LOAD_W:
  - load_weights_o = weight_valid_i, combinational.
  - The beat counter advances only on accepted beats.
  - After the ARRAY_DIM-th accepted beat, go to STREAM.
- STREAM:
  - ub_rd_o=1 for exactly H cycles; ub_rd_addr_o = ub_base + r, r = 0..H-1, wrapping mod 2^UB_ADDR_W.
  - Then go to DRAIN.
- DRAIN:
  - Lasts exactly PIPE_LAT cycles.
  - Then go to LOAD_W with tile+1 if tiles remain; otherwise go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- acc_wr_o / acc_addr_wr_o are ub_rd_o / r delayed by PIPE_LAT cycles through a valid+address delay line.
  - Accumulator address = r mod 2^ACC_ADDR_W, so rows wrap silently when H > 2^ACC_ADDR_W.
- acc_col_mask_o:
  - all ones, except on the last tile when W mod ARRAY_DIM = R ≠ 0;
  - on that tile only the low R bits are set.
  - The mask is held through that tile's DRAIN.
- Reset, asserted at any time:
  - immediate return to IDLE;
  - delay line cleared;
  - all outputs 0;
  - no write is issued for a partially streamed tile.

## Timing
- Reset values: every output is 0, including tile_idx_o, acc_col_mask_o and ub_rd_addr_o.
- Start handshake:
  - start accepted at edge E0;
  - busy_o is high from the cycle after E0 through the DONE cycle;
  - busy_o is low again in the cycle after done_o.
- Cycles per tile with weight_valid_i held high: ARRAY_DIM + H + PIPE_LAT.
- done_o is high in cycle 1 + tiles·(ARRAY_DIM+H+PIPE_LAT) after E0.
- A weight stall adds one cycle per low weight_valid_i cycle in LOAD_W. No other state stalls.
- The last acc_wr_o of a tile occurs in that tile's final DRAIN cycle, so tiles never overlap.
- H=0 or W=0: done_o is high in the cycle after E0, and no other output toggles.

## Configuration
- TILE_SEQ_PERF_EN defined:
  - adds outputs perf_cycles_o[31:0] and perf_wstall_o[31:0];
  - both saturate at all ones and clear on start acceptance.
  - perf_cycles_o counts busy cycles; perf_wstall_o counts LOAD_W cycles with weight_valid_i=0.
- TILE_SEQ_PERF_EN undefined: neither port nor counter exists. All other behaviour is identical.

## Structure
- The Acc_types package holds:
  - the state enum typedef tile_seq_state_t;
  - a ceil-divide function for the tile count.
- One sub-module, tile_seq_delay_line: a PIPE_LAT-deep valid+address shift register with async active-low clear.

## Test plan
Bench parameters: ARRAY_DIM=4, PIPE_LAT=9.
- H=3, W=4, base=0x010, valid held high:
  - 4 loads, then ub_rd_addr_o 0x010..0x012;
  - acc_wr_o at rows 0..2 exactly 9 cycles after each read;
  - done_o at cycle 17; mask 4'b1111.
- H=2, W=6: two tiles; tile_idx_o 0 then 1; tile-1 mask 4'b0011; done_o at cycle 31.
- weight_valid_i low for 5 cycles mid LOAD_W: exactly 4 load_weights_o pulses; done_o delayed by 5 cycles; with PERF_EN, perf_wstall_o=5.
- H=0, W=8: done_o the cycle after start; no ub_rd_o, load_weights_o or acc_wr_o.
- rst_i low during STREAM: all outputs 0 immediately; no acc_wr_o afterwards; a new start then completes normally.
- start_i held high for the whole run: exactly one run; the next run starts only after returning to IDLE.
